// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl
// Sequencer for the multi-cycle multiply/divide datapath in the execute stage.
// It recognises R-type mul/div, fires a one-cycle start pulse at the datapath,
// steps the datapath for LATENCY cycles while freezing the pipeline, and then
// presents a single completion cycle with register-write and rstatus controls.
// A divide by zero skips the datapath entirely and completes with code 5.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   opcode, func      instruction fields of the instruction in execute
//   issue             execute-stage instruction valid
//   data_operandB     divisor/multiplier operand (checked for zero on div)
//   md_overflow       datapath overflow flag, meaningful on the final step
//   ctrl_MULT/DIV     one-cycle start pulses to the datapath
//   md_step           datapath advance enable
//   stall             freeze fetch/decode/execute registers
//   md_done           result valid this cycle
//   md_Rwe, md_SETR   write rd / write $r30 with md_rstatus
//   md_rstatus        exception code, nonzero only on an excepting completion
//   busy              sequencer is not idle
module multdiv_ctrl #(
   parameter int LATENCY = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  opcode,
   input  logic [4:0]  func,
   input  logic        issue,
   input  logic [31:0] data_operandB,
   input  logic        md_overflow,
   output logic        ctrl_MULT,
   output logic        ctrl_DIV,
   output logic        md_step,
   output logic        stall,
   output logic        md_done,
   output logic        md_Rwe,
   output logic        md_SETR,
   output logic [31:0] md_rstatus,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [5:0] CNT_LOAD = 6'(LATENCY - 1);
   localparam logic [2:0] CODE_MUL = 3'd4;
   localparam logic [2:0] CODE_DIV = 3'd5;

   state_t     state, state_next;
   logic [5:0] cnt, cnt_next;
   logic       kind, kind_next;
   logic       exc, exc_next;
   logic [2:0] exc_code, exc_code_next;
   logic       is_mul, is_div, launch;

   // Decode of the execute-stage instruction. Launch is additionally gated by
   // reset so that a held issue cannot pulse the start lines while the block
   // is being forced back to IDLE.
   always_comb begin
      is_mul = (opcode == 5'd0) && (func == 5'd6);
      is_div = (opcode == 5'd0) && (func == 5'd7);
      launch = (state == IDLE) && issue && (is_mul || is_div) && !reset;
   end

   // State and operation bookkeeping registers. cnt counts the remaining
   // step cycles, kind remembers mul vs div for the exception code, and
   // exc/exc_code hold the outcome until the completion cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 6'd0;
         kind     <= 1'b0;
         exc      <= 1'b0;
         exc_code <= 3'd0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         kind     <= kind_next;
         exc      <= exc_next;
         exc_code <= exc_code_next;
      end
   end

   // Next-state and output logic. Everything defaults to quiet so that a
   // non-md instruction or an idle cycle drives nothing. The overflow flag is
   // only looked at on the final BUSY cycle; the completion cycle drops stall
   // so the pipeline advances past the finished instruction, which is why a
   // still-asserted issue in DONE does not relaunch.
   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      kind_next     = kind;
      exc_next      = exc;
      exc_code_next = exc_code;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      md_step       = 1'b0;
      stall         = 1'b0;
      md_done       = 1'b0;
      md_Rwe        = 1'b0;
      md_SETR       = 1'b0;
      md_rstatus    = 32'd0;
      busy          = (state != IDLE);

      case (state)
         IDLE: begin
            if (launch) begin
               stall = 1'b1;
               if (is_mul) begin
                  ctrl_MULT     = 1'b1;
                  cnt_next      = CNT_LOAD;
                  kind_next     = 1'b0;
                  exc_next      = 1'b0;
                  state_next    = BUSY;
               end else if (data_operandB != 32'd0) begin
                  ctrl_DIV      = 1'b1;
                  cnt_next      = CNT_LOAD;
                  kind_next     = 1'b1;
                  exc_next      = 1'b0;
                  state_next    = BUSY;
               end else begin
                  kind_next     = 1'b1;
                  exc_next      = 1'b1;
                  exc_code_next = CODE_DIV;
                  state_next    = DONE;
               end
            end
         end
         BUSY: begin
            md_step = 1'b1;
            stall   = 1'b1;
            if (cnt == 6'd0) begin
               exc_next      = md_overflow;
               exc_code_next = kind ? CODE_DIV : CODE_MUL;
               state_next    = DONE;
            end else begin
               cnt_next = cnt - 6'd1;
            end
         end
         DONE: begin
            md_done    = 1'b1;
            md_Rwe     = ~exc;
            md_SETR    = exc;
            md_rstatus = exc ? {29'd0, exc_code} : 32'd0;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl
// Bench for multdiv_ctrl. Directed operations are issued by applyStimulus,
// which also pushes the expected completion record into a queue; a separate
// monitor pops that queue whenever md_done is seen and compares the
// completion controls. Cycle-level timing (start pulse, step and stall
// counts, completion cycle) is measured inside applyStimulus.
module tb_multdiv_ctrl;

   localparam int L = 32;

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  opcode;
   logic [4:0]  func;
   logic        issue;
   logic [31:0] data_operandB;
   logic        md_overflow;
   logic        ctrl_MULT, ctrl_DIV, md_step, stall, md_done;
   logic        md_Rwe, md_SETR, busy;
   logic [31:0] md_rstatus;

   typedef struct packed {
      logic        rwe;
      logic        setr;
      logic [31:0] rstatus;
   } exp_t;

   exp_t expQ[$];
   int   checks   = 0;
   int   failures = 0;

   multdiv_ctrl #(.LATENCY(L)) dut (
      .clock         (clock),
      .reset         (reset),
      .opcode        (opcode),
      .func          (func),
      .issue         (issue),
      .data_operandB (data_operandB),
      .md_overflow   (md_overflow),
      .ctrl_MULT     (ctrl_MULT),
      .ctrl_DIV      (ctrl_DIV),
      .md_step       (md_step),
      .stall         (stall),
      .md_done       (md_done),
      .md_Rwe        (md_Rwe),
      .md_SETR       (md_SETR),
      .md_rstatus    (md_rstatus),
      .busy          (busy)
   );

   // Free-running clock, 10 time units per period.
   always #5 clock = ~clock;

   // One comparison: bumps the check count and reports any difference.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Monitor: every completion must match the oldest outstanding expectation,
   // and a completion with nothing outstanding is an error by itself.
   always @(negedge clock) begin
      exp_t e;
      if (!reset && md_done) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_md_done", 32'd1, 32'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("done_md_Rwe", {31'd0, md_Rwe}, {31'd0, e.rwe});
            checkOutput("done_md_SETR", {31'd0, md_SETR}, {31'd0, e.setr});
            checkOutput("done_md_rstatus", md_rstatus, e.rstatus);
            checkOutput("done_busy", {31'd0, busy}, 32'd1);
         end
      end
   end

   // Issue one instruction (entered just after a rising edge) and follow it
   // to completion. ovfLast is driven during the last step cycle, ovfOther at
   // every other cycle. With chainMul, a mul is presented during the
   // completion cycle and issue is left high for an immediate relaunch.
   task automatic applyStimulus(input string tag, input logic [4:0] op,
                                input logic [4:0] fn, input logic [31:0] opB,
                                input logic ovfLast, input logic ovfOther,
                                input int expSteps, input int expStalls,
                                input int expDone, input int expMult,
                                input int expDiv, input logic expRwe,
                                input logic expSetr, input logic [31:0] expRs,
                                input bit chainMul);
      int steps = 0;
      int stalls = 0;
      int mults = 0;
      int divs = 0;
      int doneAt = -1;
      int misplaced = 0;
      exp_t e;
      e.rwe = expRwe;
      e.setr = expSetr;
      e.rstatus = expRs;
      expQ.push_back(e);
      opcode = op;
      func = fn;
      data_operandB = opB;
      issue = 1'b1;
      for (int c = 0; c < 200; c++) begin
         md_overflow = (c == expSteps) ? ovfLast : ovfOther;
         if (chainMul && c == expDone) begin
            opcode = 5'd0;
            func = 5'd6;
         end
         @(negedge clock);
         if (md_step) steps++;
         if (stall) stalls++;
         if (ctrl_MULT) begin
            mults++;
            if (c != 0) misplaced++;
         end
         if (ctrl_DIV) begin
            divs++;
            if (c != 0) misplaced++;
         end
         if (md_done) begin
            doneAt = c;
            break;
         end
         @(posedge clock);
         #1;
      end
      checkOutput($sformatf("%s_done_cycle", tag), doneAt, expDone);
      checkOutput($sformatf("%s_step_cycles", tag), steps, expSteps);
      checkOutput($sformatf("%s_stall_cycles", tag), stalls, expStalls);
      checkOutput($sformatf("%s_mult_pulses", tag), mults, expMult);
      checkOutput($sformatf("%s_div_pulses", tag), divs, expDiv);
      checkOutput($sformatf("%s_late_start", tag), misplaced, 0);
      @(posedge clock);
      #1;
      md_overflow = 1'b0;
      if (!chainMul) issue = 1'b0;
   endtask

   // Directed sequence.
   initial begin
      int cnt;
      reset = 1'b1;
      issue = 1'b0;
      opcode = 5'd0;
      func = 5'd0;
      data_operandB = 32'd0;
      md_overflow = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      checkOutput("reset_outputs",
                  {24'd0, ctrl_MULT, ctrl_DIV, md_step, stall, md_done, md_Rwe, md_SETR, busy},
                  32'd0);
      checkOutput("reset_rstatus", md_rstatus, 32'd0);
      reset = 1'b0;

      // Non-md instructions must leave every output quiet.
      cnt = 0;
      issue = 1'b1;
      opcode = 5'd0;
      func = 5'd0;
      data_operandB = 32'd5;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         if (stall || busy || md_done || ctrl_MULT || ctrl_DIV || md_step) cnt++;
         @(posedge clock);
         #1;
      end
      checkOutput("add_quiet_cycles", cnt, 0);
      cnt = 0;
      opcode = 5'd1;
      func = 5'd6;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         if (stall || busy || md_done || ctrl_MULT || ctrl_DIV || md_step) cnt++;
         @(posedge clock);
         #1;
      end
      checkOutput("nonrtype_quiet_cycles", cnt, 0);
      issue = 1'b0;
      @(posedge clock);
      #1;

      // mul without overflow; overflow toggled high on non-final cycles must be ignored
      applyStimulus("mul", 5'd0, 5'd6, 32'd3, 1'b0, 1'b1, L, L + 1, L + 1, 1, 0,
                    1'b1, 1'b0, 32'd0, 1'b0);
      // mul with overflow on the final step
      applyStimulus("mul_ovf", 5'd0, 5'd6, 32'd3, 1'b1, 1'b0, L, L + 1, L + 1, 1, 0,
                    1'b0, 1'b1, 32'd4, 1'b0);
      // divide by zero short-circuits to completion
      applyStimulus("div0", 5'd0, 5'd7, 32'd0, 1'b0, 1'b0, 0, 1, 1, 0, 0,
                    1'b0, 1'b1, 32'd5, 1'b0);
      // div with overflow on the final step reports the divide code
      applyStimulus("div_ovf", 5'd0, 5'd7, 32'd9, 1'b1, 1'b0, L, L + 1, L + 1, 0, 1,
                    1'b0, 1'b1, 32'd5, 1'b0);
      // div by 7, then a mul held on issue through the completion cycle
      applyStimulus("div7", 5'd0, 5'd7, 32'd7, 1'b0, 1'b0, L, L + 1, L + 1, 0, 1,
                    1'b1, 1'b0, 32'd0, 1'b1);
      applyStimulus("relaunch_mul", 5'd0, 5'd6, 32'd7, 1'b0, 1'b0, L, L + 1, L + 1, 1, 0,
                    1'b1, 1'b0, 32'd0, 1'b0);

      // Reset in the middle of a mul at BUSY cycle 10
      opcode = 5'd0;
      func = 5'd6;
      data_operandB = 32'd2;
      issue = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clock);
         #1;
      end
      checkOutput("pre_reset_step", {31'd0, md_step}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midreset_outputs",
                  {24'd0, ctrl_MULT, ctrl_DIV, md_step, stall, md_done, md_Rwe, md_SETR, busy},
                  32'd0);
      checkOutput("midreset_rstatus", md_rstatus, 32'd0);
      @(posedge clock);
      #1;
      issue = 1'b0;
      reset = 1'b0;
      cnt = 0;
      for (int c = 0; c < L + 10; c++) begin
         @(negedge clock);
         if (md_done || busy) cnt++;
         @(posedge clock);
         #1;
      end
      checkOutput("post_reset_quiet_cycles", cnt, 0);
      applyStimulus("post_reset_mul", 5'd0, 5'd6, 32'd2, 1'b0, 1'b0, L, L + 1, L + 1, 1, 0,
                    1'b1, 1'b0, 32'd0, 1'b0);

      repeat (3) @(posedge clock);
      checkOutput("scoreboard_drained", expQ.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
